// File: rtl/uart_loader.sv
// Boot-time program loader: pops a length header, instruction words and a checksum from the
// UART RX FIFO, writes the words into imem, replies ACK/NAK on TX, then releases the CPU.
module uart_loader #(
   parameter int                    ADDR_WIDTH = 12,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter logic [7:0]            ACK_BYTE   = 8'hAA,
   parameter logic [7:0]            NAK_BYTE   = 8'h55
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  start,
   input  logic [7:0]            uart_rx_data,
   input  logic                  empty,
   output logic                  uart_rd_en,
   output logic [7:0]            uart_tx_data,
   input  logic                  full,
   output logic                  uart_wr_en,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  cpu_rstn,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [2:0]            state_dbg
);

   // RX handshake: a byte is consumed on every cycle uart_rd_en=1 (only when !empty).
   // TX handshake: uart_tx_data is pushed on every cycle uart_wr_en=1 (only when !full).

   typedef enum logic [2:0] {
      S_IDLE, S_HDR, S_DATA, S_CSUM, S_REPLY, S_DONE, S_ERR
   } state_t;

   localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_WIDTH;

   state_t                state, state_nxt;
   logic [1:0]            byte_cnt;
   logic [31:0]           asm_q;
   logic [31:0]           words_left;
   logic [7:0]            csum;
   logic                  ack_q;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic                  pop, push;
   logic [31:0]           word_in;
   logic                  last_byte, hdr_big, csum_ok;

   // Bytes shift in from the top so the first byte of a word ends up in [7:0].
   assign word_in   = {uart_rx_data, asm_q[31:8]};
   assign last_byte = (byte_cnt == 2'd3);
   assign hdr_big   = ({1'b0, word_in} > MAX_WORDS);
   assign csum_ok   = (uart_rx_data == csum);

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      push      = 1'b0;
      case (state)
         S_IDLE: if (start) state_nxt = S_HDR;
         S_HDR: begin
            pop = !empty;
            if (pop && last_byte) begin
               if (word_in == 32'd0) state_nxt = S_CSUM;
               else if (hdr_big)     state_nxt = S_REPLY;
               else                  state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            pop = !empty;
            if (pop && last_byte && words_left == 32'd1) state_nxt = S_CSUM;
         end
         S_CSUM: begin
            pop = !empty;
            if (pop) state_nxt = S_REPLY;
         end
         S_REPLY: begin
            push = !full;
            if (push) state_nxt = ack_q ? S_DONE : S_ERR;
         end
         S_DONE:  state_nxt = S_DONE;
         S_ERR:   state_nxt = S_ERR;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state        <= S_IDLE;
         byte_cnt     <= 2'd0;
         asm_q        <= 32'd0;
         words_left   <= 32'd0;
         csum         <= 8'd0;
         ack_q        <= 1'b0;
         wr_addr      <= BASE_ADDR;
         imem_we      <= 1'b0;
         imem_addr    <= BASE_ADDR;
         imem_wdata   <= 32'd0;
         uart_tx_data <= 8'd0;
      end else begin
         state   <= state_nxt;
         imem_we <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  byte_cnt <= 2'd0;
                  csum     <= 8'd0;
                  wr_addr  <= BASE_ADDR;
               end
            end
            S_HDR: begin
               if (pop) begin
                  asm_q    <= word_in;
                  byte_cnt <= byte_cnt + 2'd1;
                  if (last_byte) begin
                     words_left <= word_in;
                     // Zero-length loads skip straight to CSUM and are judged there.
                     if (hdr_big) begin
                        ack_q        <= 1'b0;
                        uart_tx_data <= NAK_BYTE;
                     end
                  end
               end
            end
            S_DATA: begin
               if (pop) begin
                  asm_q    <= word_in;
                  byte_cnt <= byte_cnt + 2'd1;
                  csum     <= csum + uart_rx_data;
                  if (last_byte) begin
                     imem_we    <= 1'b1;
                     imem_addr  <= wr_addr;
                     imem_wdata <= word_in;
                     wr_addr    <= wr_addr + 1'b1;
                     words_left <= words_left - 32'd1;
                  end
               end
            end
            S_CSUM: begin
               if (pop) begin
                  ack_q        <= csum_ok;
                  uart_tx_data <= csum_ok ? ACK_BYTE : NAK_BYTE;
               end
            end
            default: ;
         endcase
      end
   end

   assign uart_rd_en = pop & rstn;
   assign uart_wr_en = push & rstn;
   assign cpu_rstn   = (state == S_DONE);
   assign done       = (state == S_DONE);
   assign error      = (state == S_ERR);
   assign busy       = (state != S_IDLE) && (state != S_DONE) && (state != S_ERR);
   assign state_dbg  = state;

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: models the RX/TX FIFOs and imem, checks loads, NAKs,
// oversize headers, stalls, and reset mid-load.
module tb_uart_loader;

   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          start = 1'b0;
   logic [7:0]    uart_rx_data = 8'h00;
   logic          empty = 1'b1;
   logic          full = 1'b0;
   logic          uart_rd_en, uart_wr_en, imem_we, cpu_rstn, busy, done, error;
   logic [7:0]    uart_tx_data;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic [2:0]    state_dbg;

   int            checks = 0;
   int            errors = 0;
   int            we_cnt = 0;
   int            spurious = 0;
   bit            gap_en = 1'b0;
   bit            pop_pending = 1'b0;
   logic [7:0]    rx_q[$];
   logic [7:0]    tx_got[$];
   logic [31:0]   exp_q[$];
   logic [31:0]   mem[16];

   uart_loader #(.ADDR_WIDTH(AW)) dut (
      .clk(clk), .rstn(rstn), .start(start),
      .uart_rx_data(uart_rx_data), .empty(empty), .uart_rd_en(uart_rd_en),
      .uart_tx_data(uart_tx_data), .full(full), .uart_wr_en(uart_wr_en),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .cpu_rstn(cpu_rstn), .busy(busy), .done(done), .error(error),
      .state_dbg(state_dbg)
   );

   // clock
   always #5 clk = ~clk;

   // RX FIFO / TX FIFO / imem models: inputs change at negedge, outputs sampled 1 unit later.
   always @(negedge clk) begin
      if (pop_pending) begin
         if (rx_q.size() > 0) void'(rx_q.pop_front());
         else spurious++;
      end
      if (rx_q.size() > 0 && !(gap_en && $urandom_range(0, 2) == 0)) begin
         empty        = 1'b0;
         uart_rx_data = rx_q[0];
      end else begin
         empty        = 1'b1;
         uart_rx_data = 8'h00;
      end
      #1;
      pop_pending = uart_rd_en;
      if (uart_wr_en) tx_got.push_back(uart_tx_data);
      if (imem_we) begin
         mem[imem_addr] = imem_wdata;
         we_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] tx0();
      return (tx_got.size() > 0) ? {24'd0, tx_got[0]} : 32'hxxxxxxxx;
   endfunction

   task automatic do_reset();
      rstn   = 1'b0;
      start  = 1'b0;
      full   = 1'b0;
      gap_en = 1'b0;
      repeat (2) @(negedge clk);
      rx_q.delete();
      tx_got.delete();
      exp_q.delete();
      we_cnt = 0;
      for (int i = 0; i < 16; i++) mem[i] = 32'hDEADBEEF;
      rstn = 1'b1;
      @(negedge clk);
   endtask

   task automatic push_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) rx_q.push_back(w[8*i +: 8]);
   endtask

   task automatic go();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_end(input string tag, input int budget);
      int n = 0;
      while (!(done || error) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, {31'd0, done | error}, 32'd1);
   endtask

   task automatic wait_rx_left(input string tag, input int left, input int budget);
      int n = 0;
      while (rx_q.size() > left && n < budget) begin
         @(negedge clk);
         #2;
         n++;
      end
      chk(tag, rx_q.size(), left);
   endtask

   task automatic push_basic(input logic [7:0] cs);
      push_word(32'd2);
      push_word(32'h00000013);
      push_word(32'h00100093);
      rx_q.push_back(cs);
   endtask

   initial begin
      logic [31:0] w;
      logic [7:0]  cs;

      // reset state
      do_reset();
      chk("rst_cpu_rstn", cpu_rstn, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_busy", busy, 0);
      chk("rst_imem_we", imem_we, 0);
      chk("rst_imem_addr", imem_addr, 0);
      chk("rst_tx_data", uart_tx_data, 0);
      chk("rst_rd_en", uart_rd_en, 0);

      // 1: good load of two words, queued bytes wait for start
      push_basic(8'hB6);
      repeat (5) @(negedge clk);
      chk("t1_no_pop_before_start", rx_q.size(), 13);
      go();
      wait_end("t1_timeout", 200);
      chk("t1_done", done, 1);
      chk("t1_error", error, 0);
      chk("t1_cpu_rstn", cpu_rstn, 1);
      chk("t1_busy", busy, 0);
      chk("t1_mem0", mem[0], 32'h00000013);
      chk("t1_mem1", mem[1], 32'h00100093);
      chk("t1_we_cnt", we_cnt, 2);
      chk("t1_tx_cnt", tx_got.size(), 1);
      chk("t1_tx", tx0(), 32'hAA);
      go();
      repeat (5) @(negedge clk);
      chk("t1_start_ignored", {31'd0, done}, 1);
      chk("t1_we_after", we_cnt, 2);

      // 2: bad checksum
      do_reset();
      push_basic(8'h00);
      go();
      wait_end("t2_timeout", 200);
      chk("t2_error", error, 1);
      chk("t2_done", done, 0);
      chk("t2_cpu_rstn", cpu_rstn, 0);
      chk("t2_mem0", mem[0], 32'h00000013);
      chk("t2_mem1", mem[1], 32'h00100093);
      chk("t2_tx", tx0(), 32'h55);

      // 3: zero-length load
      do_reset();
      push_word(32'd0);
      rx_q.push_back(8'h00);
      go();
      wait_end("t3_timeout", 200);
      chk("t3_done", done, 1);
      chk("t3_we_cnt", we_cnt, 0);
      chk("t3_tx", tx0(), 32'hAA);

      // 4: oversize header (17 > 16), trailing bytes must stay queued
      do_reset();
      push_word(32'd17);
      push_word(32'h11223344);
      go();
      wait_end("t4_timeout", 200);
      repeat (4) @(negedge clk);
      chk("t4_error", error, 1);
      chk("t4_tx", tx0(), 32'h55);
      chk("t4_we_cnt", we_cnt, 0);
      chk("t4_rx_left", rx_q.size(), 4);

      // 4b: maximum length exactly fills imem
      do_reset();
      cs = 8'h00;
      push_word(32'd16);
      for (int i = 0; i < 16; i++) begin
         w = $urandom;
         exp_q.push_back(w);
         push_word(w);
         cs = cs + w[7:0] + w[15:8] + w[23:16] + w[31:24];
      end
      rx_q.push_back(cs);
      go();
      wait_end("t4b_timeout", 400);
      chk("t4b_done", done, 1);
      chk("t4b_we_cnt", we_cnt, 16);
      for (int i = 0; i < 16; i++) chk($sformatf("t4b_mem%0d", i), mem[i], exp_q.pop_front());

      // 5: random RX gaps and TX full held in REPLY
      do_reset();
      full   = 1'b1;
      gap_en = 1'b1;
      push_basic(8'hB6);
      go();
      wait_rx_left("t5_rx_drain", 0, 300);
      repeat (20) @(negedge clk);
      chk("t5_busy_held", busy, 1);
      chk("t5_state_reply", state_dbg, 3'd4);
      chk("t5_no_tx_while_full", tx_got.size(), 0);
      full = 1'b0;
      wait_end("t5_timeout", 50);
      chk("t5_done", done, 1);
      chk("t5_tx_cnt", tx_got.size(), 1);
      chk("t5_tx", tx0(), 32'hAA);
      chk("t5_mem0", mem[0], 32'h00000013);
      chk("t5_mem1", mem[1], 32'h00100093);

      // 6: reset after two data bytes, then a fresh load
      do_reset();
      push_basic(8'hB6);
      go();
      wait_rx_left("t6_partial", 7, 100);
      rstn = 1'b0;
      chk("t6_no_write_yet", we_cnt, 0);
      do_reset();
      chk("t6_idle_after_rst", state_dbg, 3'd0);
      push_word(32'd2);
      push_word(32'hCAFEF00D);
      push_word(32'h12345678);
      rx_q.push_back(8'hD9);
      repeat (4) @(negedge clk);
      chk("t6_no_pop_before_start", rx_q.size(), 13);
      go();
      wait_end("t6_timeout", 200);
      chk("t6_done", done, 1);
      chk("t6_mem0", mem[0], 32'hCAFEF00D);
      chk("t6_mem1", mem[1], 32'h12345678);
      chk("t6_we_cnt", we_cnt, 2);
      chk("t6_tx", tx0(), 32'hAA);

      chk("spurious_pop", spurious, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
